// File: rtl/debug_insn_sequencer_pkg.sv
// Shared types for the debug instruction sequencer: trimmed RV32I opcodes,
// CSR function codes, debug CSR addresses and the sequencer state encoding.
package debug_insn_sequencer_pkg;

  // Major opcodes with the always-11 low bits stripped off
  typedef enum logic [4:0] {
    LUI_T       = 5'b01101,
    ARITH_IMM_T = 5'b00100,
    SYSTEM_T    = 5'b11100
  } opcodes_trimmed_t;

  // funct3 values of the SYSTEM-opcode CSR instructions
  typedef enum logic [2:0] {
    CSRRW_FN3 = 3'b001,
    CSRRS_FN3 = 3'b010
  } fn3_csr_t;

  // Debug-mode CSR addresses used by the sequencer
  typedef enum logic [11:0] {
    DSCRATCH = 12'h7B2
  } csr_reg_addr_t;

  // Instruction formats the encoder knows how to pack
  typedef enum logic {
    FMT_I = 1'b0,
    FMT_U = 1'b1
  } insn_fmt_t;

  localparam logic [2:0] ADDI_FN3 = 3'b000;
  localparam logic [4:0] X0       = 5'd0;

  // Sequencer states
  localparam int         SEQ_STATE_W = 3;
  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] EMIT_LUI    = 3'd1;
  localparam logic [2:0] EMIT_ADDI   = 3'd2;
  localparam logic [2:0] EMIT_CSR    = 3'd3;
  localparam logic [2:0] EMIT_XFER   = 3'd4;
  localparam logic [2:0] DONE        = 3'd5;

  // Rebuild the full 7-bit opcode from its trimmed form
  function automatic logic [6:0] full_opcode(input opcodes_trimmed_t op);
    return {op, 2'b11};
  endfunction

  // Upper LUI immediate, pre-compensated for ADDI sign-extending bit 11
  function automatic logic [19:0] const_hi(input logic [31:0] data);
    return data[31:12] + {19'd0, data[11]};
  endfunction

  // Lower ADDI immediate; the hart sign-extends it
  function automatic logic [11:0] const_lo(input logic [31:0] data);
    return data[11:0];
  endfunction

endpackage

// File: rtl/rv32_insn_encoder.sv
// Purely combinational RV32I field packer for the I-type and U-type formats
// emitted by the debug instruction sequencer.
module rv32_insn_encoder
  import debug_insn_sequencer_pkg::*;
(
  input  insn_fmt_t   fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  fn3,
  input  logic [4:0]  rs1,
  input  logic [19:0] imm,
  output logic [31:0] insn
);

  // U-type takes the full 20-bit immediate; I-type uses only imm[11:0]
  always_comb begin
    insn = '0;
    if (fmt == FMT_U) begin
      insn = {imm, rd, opcode};
    end else begin
      insn = {imm[11:0], rs1, fn3, rd, opcode};
    end
  end

endmodule

// File: rtl/debug_insn_sequencer.sv
// Turns debugger abstract register commands into short RV32I instruction
// sequences injected into the hart's fetch path, one instruction per
// handshake, then pulses done (with err for rejected commands).
module debug_insn_sequencer
  import debug_insn_sequencer_pkg::*;
#(
  parameter logic [4:0]  SCRATCH_GPR = 5'd8,
  parameter logic [11:0] XFER_CSR    = DSCRATCH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_is_csr,
  input  logic [11:0] cmd_regno,
  input  logic [31:0] cmd_data,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic        done,
  output logic        err
);

  logic [SEQ_STATE_W-1:0] state;
  logic [SEQ_STATE_W-1:0] next_state;

  logic        lat_write;
  logic        lat_is_csr;
  logic [11:0] lat_regno;
  logic [31:0] lat_data;
  logic        err_q;

  logic        accept;
  logic        advance;
  logic        bad_gpr;

  logic        sel_write;
  logic        sel_is_csr;
  logic [11:0] sel_regno;
  logic [31:0] sel_data;
  logic [4:0]  target_rd;

  logic        next_emits;
  insn_fmt_t   enc_fmt;
  logic [6:0]  enc_opcode;
  logic [4:0]  enc_rd;
  logic [4:0]  enc_rs1;
  logic [2:0]  enc_fn3;
  logic [19:0] enc_imm;
  logic [31:0] enc_insn;

  assign cmd_ready  = (state == IDLE) && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign insn_valid = (state == EMIT_LUI) || (state == EMIT_ADDI) ||
                      (state == EMIT_CSR) || (state == EMIT_XFER);
  assign advance    = insn_valid && insn_ready;
  assign done       = (state == DONE);
  assign err        = done && err_q;

  // In IDLE the command is still on the inputs; afterwards the latched copy
  // is used, so the next instruction can be encoded on the accept edge.
  assign sel_write  = (state == IDLE) ? cmd_write  : lat_write;
  assign sel_is_csr = (state == IDLE) ? cmd_is_csr : lat_is_csr;
  assign sel_regno  = (state == IDLE) ? cmd_regno  : lat_regno;
  assign sel_data   = (state == IDLE) ? cmd_data   : lat_data;

  // CSR transfers stage the value through the scratch GPR
  assign target_rd  = sel_is_csr ? SCRATCH_GPR : sel_regno[4:0];

  // GPR indices above x31 are rejected outright
  assign bad_gpr    = !cmd_is_csr && (cmd_regno[11:5] != 7'd0);

  // Sequence selection on accept, then one step per accepted instruction
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad_gpr) begin
            next_state = DONE;
          end else if (cmd_is_csr) begin
            next_state = cmd_write ? EMIT_LUI : EMIT_CSR;
          end else if (cmd_write) begin
            next_state = (cmd_regno[4:0] == X0) ? DONE : EMIT_LUI;
          end else begin
            next_state = EMIT_XFER;
          end
        end
      end
      EMIT_LUI: begin
        if (advance) next_state = EMIT_ADDI;
      end
      EMIT_ADDI: begin
        if (advance) next_state = sel_is_csr ? EMIT_CSR : DONE;
      end
      EMIT_CSR: begin
        if (advance) next_state = sel_write ? DONE : EMIT_XFER;
      end
      EMIT_XFER: begin
        if (advance) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign next_emits = (next_state == EMIT_LUI) || (next_state == EMIT_ADDI) ||
                      (next_state == EMIT_CSR) || (next_state == EMIT_XFER);

  // Instruction fields for whichever EMIT state is about to be entered
  always_comb begin
    enc_fmt    = FMT_I;
    enc_opcode = full_opcode(SYSTEM_T);
    enc_rd     = X0;
    enc_rs1    = X0;
    enc_fn3    = CSRRW_FN3;
    enc_imm    = '0;
    case (next_state)
      EMIT_LUI: begin
        enc_fmt    = FMT_U;
        enc_opcode = full_opcode(LUI_T);
        enc_rd     = target_rd;
        enc_imm    = const_hi(sel_data);
      end
      EMIT_ADDI: begin
        enc_opcode = full_opcode(ARITH_IMM_T);
        enc_fn3    = ADDI_FN3;
        enc_rd     = target_rd;
        enc_rs1    = target_rd;
        enc_imm    = {8'd0, const_lo(sel_data)};
      end
      EMIT_CSR: begin
        enc_imm = {8'd0, sel_regno};
        if (sel_write) begin
          enc_fn3 = CSRRW_FN3;
          enc_rs1 = SCRATCH_GPR;
        end else begin
          enc_fn3 = CSRRS_FN3;
          enc_rd  = SCRATCH_GPR;
        end
      end
      EMIT_XFER: begin
        enc_fn3 = CSRRW_FN3;
        enc_rs1 = target_rd;
        enc_imm = {8'd0, XFER_CSR};
      end
      default: begin
        enc_fmt = FMT_I;
      end
    endcase
  end

  rv32_insn_encoder u_encoder (
    .fmt    (enc_fmt),
    .opcode (enc_opcode),
    .rd     (enc_rd),
    .fn3    (enc_fn3),
    .rs1    (enc_rs1),
    .imm    (enc_imm),
    .insn   (enc_insn)
  );

  // State, registered instruction and error flag; reset abandons any sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      insn  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= next_state;
      insn  <= next_emits ? enc_insn : 32'd0;
      if (accept) err_q <= bad_gpr;
    end
  end

  // Command capture; data-path only, so no reset is needed
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write  <= cmd_write;
      lat_is_csr <= cmd_is_csr;
      lat_regno  <= cmd_regno;
      lat_data   <= cmd_data;
    end
  end

endmodule

// File: tb/tb_debug_insn_sequencer.sv
// Self-checking bench for debug_insn_sequencer: directed vector table,
// randomized commands against a behavioural model, and hand-written
// stall and mid-sequence reset scenarios.
module tb_debug_insn_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_is_csr;
  logic [11:0] cmd_regno;
  logic [31:0] cmd_data;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  bit          exp_err;

  typedef struct {
    bit          w;
    bit          c;
    logic [11:0] r;
    logic [31:0] d;
    int          n;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] i2;
    bit          e;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  debug_insn_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_is_csr (cmd_is_csr),
    .cmd_regno  (cmd_regno),
    .cmd_data   (cmd_data),
    .insn_valid (insn_valid),
    .insn_ready (insn_ready),
    .insn       (insn),
    .done       (done),
    .err        (err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] encU(input logic [4:0] rd, input logic [31:0] upper);
    return (upper << 12) | (32'(rd) << 7) | 32'h37;
  endfunction

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] fn3, input logic [4:0] rd,
                                       input logic [6:0] op);
    return (32'(imm) << 20) | (32'(rs1) << 15) | (32'(fn3) << 12) | (32'(rd) << 7) | 32'(op);
  endfunction

  // Expected instruction list and error flag for one abstract command
  task automatic modelCommand(input bit w, input bit c, input logic [11:0] r, input logic [31:0] d);
    logic [31:0] upper;
    logic [4:0]  g;
    upper = (d + 32'h800) >> 12;
    g     = r[4:0];
    exp_q.delete();
    exp_err = 1'b0;
    if (!c) begin
      if (r > 12'd31) begin
        exp_err = 1'b1;
      end else if (w) begin
        if (r != 12'd0) begin
          exp_q.push_back(encU(g, upper));
          exp_q.push_back(encI(d[11:0], g, 3'd0, g, 7'h13));
        end
      end else begin
        exp_q.push_back(encI(12'h7B2, g, 3'd1, 5'd0, 7'h73));
      end
    end else if (w) begin
      exp_q.push_back(encU(5'd8, upper));
      exp_q.push_back(encI(d[11:0], 5'd8, 3'd0, 5'd8, 7'h13));
      exp_q.push_back(encI(r, 5'd8, 3'd1, 5'd0, 7'h73));
    end else begin
      exp_q.push_back(encI(r, 5'd0, 3'd2, 5'd8, 7'h73));
      exp_q.push_back(encI(12'h7B2, 5'd8, 3'd1, 5'd0, 7'h73));
    end
  endtask

  // Issue one command from IDLE, collect the injected instructions and stop
  // on the cycle after done, sampling 1ns after each rising edge.
  task automatic applyStimulus(input bit w, input bit c, input logic [11:0] r, input logic [31:0] d,
                               input bit rand_ready, input int stall_first,
                               output int done_cycle, output bit got_err);
    int          stalls;
    bit          held;
    logic [31:0] held_insn;
    got_q.delete();
    done_cycle = -1;
    got_err    = 1'b0;
    stalls     = 0;
    held       = 1'b0;
    held_insn  = '0;
    cmd_valid  = 1'b1;
    cmd_write  = w;
    cmd_is_csr = c;
    cmd_regno  = r;
    cmd_data   = d;
    insn_ready = 1'b1;
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'($urandom_range(0, 1));
    cmd_is_csr = 1'($urandom_range(0, 1));
    cmd_regno  = 12'($urandom());
    cmd_data   = $urandom();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (held) begin
        checkOutput("insn_held", insn, held_insn);
        checkOutput("valid_held", 32'(insn_valid), 32'd1);
      end
      checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (done) begin
        done_cycle = cyc;
        got_err    = err;
        insn_ready = 1'b1;
        checkOutput("valid_at_done", 32'(insn_valid), 32'd0);
        break;
      end
      checkOutput("err_low_busy", 32'(err), 32'd0);
      checkOutput("valid_busy", 32'(insn_valid), 32'd1);
      if (got_q.size() == 0 && stalls < stall_first) begin
        insn_ready = 1'b0;
        stalls++;
      end else if (rand_ready) begin
        insn_ready = ($urandom_range(0, 3) != 0);
      end else begin
        insn_ready = 1'b1;
      end
      held      = insn_valid && !insn_ready;
      held_insn = insn;
      if (insn_valid && insn_ready) got_q.push_back(insn);
      @(posedge clk); #1;
    end
    if (done_cycle < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: no done within 40 cycles, expected one");
    end else begin
      @(posedge clk); #1;
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("err_after_done", 32'(err), 32'd0);
      checkOutput("idle_again", 32'(cmd_ready), 32'd1);
    end
  endtask

  // Global time limit so a wedged DUT still ends the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int          dc;
    bit          ge;
    logic [31:0] tv[3];
    bit          rw;
    bit          rc;
    logic [11:0] rr;
    logic [31:0] rd;

    vecs[0] = '{1'b1, 1'b0, 12'd5,     32'h12345FFF, 2, 32'h123462B7, 32'hFFF28293, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 12'd10,    32'h0,        1, 32'h7B251073, 32'h0,        32'h0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 12'h341,   32'h0,        2, 32'h34102473, 32'h7B241073, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 12'h305,   32'h00000800, 3, 32'h00001437, 32'h80040413, 32'h30541073, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 12'd0,     32'hDEADBEEF, 0, 32'h0,        32'h0,        32'h0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 12'h020,   32'h0,        0, 32'h0,        32'h0,        32'h0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 12'd31,    32'h00000123, 2, 32'h00000FB7, 32'h123F8F93, 32'h0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 12'd1,     32'hFFFFF800, 2, 32'h000000B7, 32'h80008093, 32'h0, 1'b0};

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_is_csr = 1'b0;
    cmd_regno  = '0;
    cmd_data   = '0;
    insn_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("reset_insn_valid", 32'(insn_valid), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_insn", insn, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].w, vecs[i].c, vecs[i].r, vecs[i].d, 1'b0, 0, dc, ge);
      tv[0] = vecs[i].i0;
      tv[1] = vecs[i].i1;
      tv[2] = vecs[i].i2;
      checkOutput($sformatf("vec%0d_count", i), 32'(got_q.size()), 32'(vecs[i].n));
      for (int k = 0; k < vecs[i].n && k < got_q.size(); k++)
        checkOutput($sformatf("vec%0d_insn%0d", i, k), got_q[k], tv[k]);
      checkOutput($sformatf("vec%0d_err", i), 32'(ge), 32'(vecs[i].e));
      checkOutput($sformatf("vec%0d_latency", i), 32'(dc), 32'(vecs[i].n + 1));
    end

    $display("[TB] CSR read with stalled first instruction");
    applyStimulus(1'b0, 1'b1, 12'h341, 32'h0, 1'b0, 3, dc, ge);
    checkOutput("stall_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      checkOutput("stall_insn0", got_q[0], 32'h34102473);
      checkOutput("stall_insn1", got_q[1], 32'h7B241073);
    end
    checkOutput("stall_latency", 32'(dc), 32'd6);
    checkOutput("stall_err", 32'(ge), 32'd0);

    $display("[TB] reset during CSR write");
    cmd_valid  = 1'b1;
    cmd_write  = 1'b1;
    cmd_is_csr = 1'b1;
    cmd_regno  = 12'h305;
    cmd_data   = 32'h00000800;
    insn_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("rstseq_lui", insn, 32'h00001437);
    @(posedge clk); #1;
    checkOutput("rstseq_addi", insn, 32'h80040413);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstseq_valid", 32'(insn_valid), 32'd0);
    checkOutput("rstseq_insn", insn, 32'd0);
    checkOutput("rstseq_done", 32'(done), 32'd0);
    checkOutput("rstseq_err", 32'(err), 32'd0);
    checkOutput("rstseq_ready_in_rst", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rstseq_ready_after", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("rstseq_no_done", 32'(done), 32'd0);
      checkOutput("rstseq_no_valid", 32'(insn_valid), 32'd0);
    end

    $display("[TB] randomized commands against model");
    for (int n = 0; n < 60; n++) begin
      rw = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      if (rc) rr = 12'($urandom());
      else if ($urandom_range(0, 4) != 0) rr = 12'($urandom_range(0, 31));
      else rr = 12'($urandom());
      if (!rc && $urandom_range(0, 7) == 0) rr = 12'd0;
      rd = $urandom();
      modelCommand(rw, rc, rr, rd);
      applyStimulus(rw, rc, rr, rd, 1'b1, 0, dc, ge);
      checkOutput($sformatf("rand%0d_count", n), 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
        checkOutput($sformatf("rand%0d_insn%0d", n, k), got_q[k], exp_q[k]);
      checkOutput($sformatf("rand%0d_err", n), 32'(ge), 32'(exp_err));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_insn_sequencer.md
DEBUG_INSN_SEQUENCER -- requirements
Module: debug_insn_sequencer

Interface
REQ-001 SHALL have parameter SCRATCH_GPR, default 5'd8 (s0), the debugger-reserved GPR used for CSR transfers.
REQ-002 SHALL have parameter XFER_CSR, default 12'h7B2 (DSCRATCH), the CSR through which data moves between hart and debugger.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: cmd_valid  input  1  abstract command offered.
REQ-006 Port: cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 Port: cmd_write  input  1  1 = write register, 0 = read register.
REQ-008 Port: cmd_is_csr  input  1  1 = CSR target, 0 = GPR target.
REQ-009 Port: cmd_regno  input  12  CSR address, or GPR index in bits [4:0].
REQ-010 Port: cmd_data  input  32  write data; ignored for reads.
REQ-011 Port: insn_valid  output  1  encoded instruction offered to the fetch-injection port.
REQ-012 Port: insn_ready  input  1  injection port accepts insn.
REQ-013 Port: insn  output  32  encoded RV32I instruction.
REQ-014 Port: done  output  1  one-cycle pulse when the command completes.
REQ-015 Port: err  output  1  qualifies done; command rejected without emitting instructions.

Function
REQ-016 SHALL use FSM states IDLE, EMIT_LUI, EMIT_ADDI, EMIT_CSR, EMIT_XFER, DONE.
REQ-017 cmd_ready SHALL be high only in IDLE; command fields SHALL be latched on the cmd_valid&&cmd_ready cycle.
REQ-018 insn_valid SHALL be high in every EMIT_* state; insn SHALL be registered and stable while insn_valid&&!insn_ready.
REQ-019 A state SHALL advance only on the insn_valid&&insn_ready cycle; at most one instruction per cycle.
REQ-020 Constant split: hi = data[31:12] + data[11] (mod 2^20); lo = data[11:0] (sign-extended by hardware).
REQ-021 GPR write rd!=0: EMIT_LUI (LUI rd,hi) -> EMIT_ADDI (ADDI rd,rd,lo) -> DONE.
REQ-022 GPR read: EMIT_XFER (CSRRW x0,XFER_CSR,rs1=rd) -> DONE.
REQ-023 CSR write: EMIT_LUI (LUI SCRATCH_GPR,hi) -> EMIT_ADDI (ADDI SCRATCH_GPR,SCRATCH_GPR,lo) -> EMIT_CSR (CSRRW x0,csr,SCRATCH_GPR) -> DONE.
REQ-024 CSR read: EMIT_CSR (CSRRS SCRATCH_GPR,csr,x0) -> EMIT_XFER (CSRRW x0,XFER_CSR,SCRATCH_GPR) -> DONE.
REQ-025 GPR write to x0 SHALL emit nothing: IDLE -> DONE, err=0.
REQ-026 GPR access with cmd_regno[11:5]!=0 SHALL emit nothing: IDLE -> DONE, err=1.
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE; err=0 outside DONE.
REQ-028 LUI opcode SHALL be 7'h37, ADDI 7'h13 fn3 000, SYSTEM 7'h73 with CSRRW fn3 001 and CSRRS fn3 010.
REQ-029 Latency with insn_ready tied high: N instructions -> done asserted N+1 cycles after acceptance (error/x0 case: 1 cycle).

Reset
REQ-030 rst SHALL force IDLE, insn_valid=0, done=0, err=0, insn=0 on the next edge, also mid-sequence; a partial sequence is abandoned, not resumed.
REQ-031 cmd_ready SHALL be 0 while rst is high and 1 the first cycle after.

Structure
REQ-032 Opcode/fn3 values SHALL come from riscv_types (opcodes_trimmed_t with 2'b11 appended, fn3_csr_t, csr_reg_addr_t DSCRATCH); a new sequencer-state enum SHALL be added to cva5_types.
REQ-033 One combinational sub-module, rv32_insn_encoder (I/U-type field packing), is natural; no other hierarchy.

Verification
REQ-034 GPR write x5=0x12345FFF, insn_ready=1 -> 0x123462B7 then 0xFFF28293, done 3 cycles after accept, err=0.
REQ-035 GPR read x10 -> single insn 0x7B251073, then done.
REQ-036 CSR read MEPC (0x341) -> 0x34102473 then 0x7B241073; insn_ready low 3 cycles on first insn -> insn held constant.
REQ-037 GPR write x0, and GPR access regno=12'h020 -> no insn_valid; done next cycle with err=0 and err=1 respectively.
REQ-038 CSR write MTVEC=0x00000800 -> 0x00001437, 0x80040413, 0x30541073; rst asserted during second insn -> IDLE, insn_valid=0, no done.
